// File: rtl/crossbar_sched.sv
// Pairs PHVs with their lookup actions and hands matched pairs to the crossbar.
// Two independent FIFOs feed one registered output slot; a timer flags orphans.

module crossbar_sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] wr_data,
    input  logic         wr_en,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // Storage is not reset: pointers and count already hide stale entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module crossbar_sched #(
    parameter int PHV_LEN    = 2304,
    parameter int ACT_LEN    = 64,
    parameter int C_NUM_PHVS = 65,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PHV_LEN-1:0]            phv_in,
    input  logic                          phv_in_valid,
    output logic                          phv_ready_out,
    input  logic [ACT_LEN*C_NUM_PHVS-1:0] action_in,
    input  logic                          action_in_valid,
    output logic                          action_ready_out,
    output logic [PHV_LEN-1:0]            phv_out,
    output logic [ACT_LEN*C_NUM_PHVS-1:0] action_out,
    output logic                          out_valid,
    input  logic                          xbar_ready_in,
    output logic [31:0]                   pair_cnt,
    output logic                          err_orphan
);
    localparam int          AW  = ACT_LEN * C_NUM_PHVS;
    localparam logic [7:0]  TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
    logic [AW-1:0]     action_out_q, action_out_d;
    logic [31:0]       pair_cnt_q, pair_cnt_d;
    logic [7:0]        orphan_timer_q, orphan_timer_d;
    logic              err_orphan_q, err_orphan_d;

    logic              phv_full, phv_empty, act_full, act_empty;
    logic              phv_push, act_push;
    logic [PHV_LEN-1:0] phv_head;
    logic [AW-1:0]     act_head;
    logic              slot_free, load, one_side;

    assign phv_ready_out    = !phv_full;
    assign action_ready_out = !act_full;
    assign phv_push         = phv_in_valid && phv_ready_out;
    assign act_push         = action_in_valid && action_ready_out;

    crossbar_sched_fifo #(.W(PHV_LEN), .DEPTH(DEPTH)) u_phv_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (phv_in),
        .wr_en   (phv_push),
        .rd_en   (load),
        .rd_data (phv_head),
        .full    (phv_full),
        .empty   (phv_empty)
    );

    crossbar_sched_fifo #(.W(AW), .DEPTH(DEPTH)) u_act_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (action_in),
        .wr_en   (act_push),
        .rd_en   (load),
        .rd_data (act_head),
        .full    (act_full),
        .empty   (act_empty)
    );

    // Both FIFOs pop on the same load so pairs can never skew.
    assign slot_free = (state_q == IDLE) || xbar_ready_in;
    assign load      = slot_free && !phv_empty && !act_empty;
    assign one_side  = phv_empty ^ act_empty;

    always_comb begin
        state_d        = state_q;
        phv_out_d      = phv_out_q;
        action_out_d   = action_out_q;
        pair_cnt_d     = pair_cnt_q;
        orphan_timer_d = '0;
        err_orphan_d   = err_orphan_q;

        if (slot_free) begin
            if (load) begin
                state_d      = SEND;
                phv_out_d    = phv_head;
                action_out_d = act_head;
                pair_cnt_d   = pair_cnt_q + 32'd1;
            end else begin
                state_d = IDLE;
            end
        end else begin
            state_d = STALL;
        end

        if (one_side) begin
            orphan_timer_d = (orphan_timer_q >= TMO) ? TMO
                                                     : orphan_timer_q + 8'd1;
            if (orphan_timer_d == TMO) begin
                err_orphan_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            phv_out_q      <= '0;
            action_out_q   <= '0;
            pair_cnt_q     <= '0;
            orphan_timer_q <= '0;
            err_orphan_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            phv_out_q      <= phv_out_d;
            action_out_q   <= action_out_d;
            pair_cnt_q     <= pair_cnt_d;
            orphan_timer_q <= orphan_timer_d;
            err_orphan_q   <= err_orphan_d;
        end
    end

    assign out_valid  = (state_q != IDLE);
    assign phv_out    = phv_out_q;
    assign action_out = action_out_q;
    assign pair_cnt   = pair_cnt_q;
    assign err_orphan = err_orphan_q;
endmodule

// File: tb/tb_crossbar_sched.sv
// Scoreboard bench for crossbar_sched: accepted pushes are queued and
// compared against every pair the crossbar takes.

module tb_crossbar_sched;
    localparam int PW = 64;
    localparam int AL = 8;
    localparam int NC = 4;
    localparam int AW = AL * NC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] phv_in = '0;
    logic          phv_in_valid = 1'b0;
    logic          phv_ready_out;
    logic [AW-1:0] action_in = '0;
    logic          action_in_valid = 1'b0;
    logic          action_ready_out;
    logic [PW-1:0] phv_out;
    logic [AW-1:0] action_out;
    logic          out_valid;
    logic          xbar_ready_in = 1'b1;
    logic [31:0]   pair_cnt;
    logic          err_orphan;

    int checks = 0;
    int errors = 0;
    int n_pairs = 0;
    int base;
    logic [PW-1:0] phv_q[$];
    logic [AW-1:0] act_q[$];

    crossbar_sched #(
        .PHV_LEN(PW), .ACT_LEN(AL), .C_NUM_PHVS(NC),
        .DEPTH(4), .TIMEOUT(255)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .phv_in           (phv_in),
        .phv_in_valid     (phv_in_valid),
        .phv_ready_out    (phv_ready_out),
        .action_in        (action_in),
        .action_in_valid  (action_in_valid),
        .action_ready_out (action_ready_out),
        .phv_out          (phv_out),
        .action_out       (action_out),
        .out_valid        (out_valid),
        .xbar_ready_in    (xbar_ready_in),
        .pair_cnt         (pair_cnt),
        .err_orphan       (err_orphan)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            if (phv_in_valid && phv_ready_out) phv_q.push_back(phv_in);
            if (action_in_valid && action_ready_out) act_q.push_back(action_in);
        end
    end

    // A pair shown with xbar ready is consumed at the coming edge.
    always @(negedge clk) begin
        if (!rst && out_valid && xbar_ready_in) begin
            if (phv_q.size() == 0 || act_q.size() == 0) begin
                check("unexpected_pair", 64'(1), 64'(0));
            end else begin
                check("pair_phv", 64'(phv_out), 64'(phv_q.pop_front()));
                check("pair_act", 64'(action_out), 64'(act_q.pop_front()));
            end
            n_pairs++;
        end
    end

    task automatic push_both(input logic [PW-1:0] p, input logic [AW-1:0] a);
        phv_in = p; action_in = a;
        phv_in_valid = 1'b1; action_in_valid = 1'b1;
        step();
        phv_in_valid = 1'b0; action_in_valid = 1'b0;
    endtask

    task automatic push_phv(input logic [PW-1:0] p);
        phv_in = p; phv_in_valid = 1'b1;
        step();
        phv_in_valid = 1'b0;
    endtask

    task automatic push_act(input logic [AW-1:0] a);
        action_in = a; action_in_valid = 1'b1;
        step();
        action_in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((phv_q.size() != 0 || act_q.size() != 0 || out_valid) && k < 100) begin
            step();
            k++;
        end
        check("drain_timeout", 64'(k >= 100), 64'(0));
    endtask

    initial begin
        step(2);
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_phv", 64'(phv_out), 64'(0));
        check("rst_act", 64'(action_out), 64'(0));
        check("rst_cnt", 64'(pair_cnt), 64'(0));
        check("rst_err", 64'(err_orphan), 64'(0));
        check("rst_prdy", 64'(phv_ready_out), 64'(1));
        check("rst_ardy", 64'(action_ready_out), 64'(1));
        rst = 1'b0;
        step();

        // single pair and latency
        push_both({8{8'hA5}}, {4{8'h11}});
        check("lat_early", 64'(out_valid), 64'(0));
        step();
        check("single_valid", 64'(out_valid), 64'(1));
        check("single_phv", 64'(phv_out), {8{8'hA5}});
        check("single_act", 64'(action_out), 64'({4{8'h11}}));
        check("single_cnt", 64'(pair_cnt), 64'(1));
        step();
        check("single_idle", 64'(out_valid), 64'(0));

        // skewed arrival
        base = n_pairs;
        for (int i = 0; i < 3; i++) push_phv(PW'(64'h1000 + i));
        step(10);
        push_act(32'h2000);
        push_act(32'h2001);
        check("skew_v1", 64'(out_valid), 64'(1));
        push_act(32'h2002);
        check("skew_v2", 64'(out_valid), 64'(1));
        step();
        check("skew_v3", 64'(out_valid), 64'(1));
        check("skew_cnt", 64'(pair_cnt), 64'(4));
        step();
        check("skew_end", 64'(out_valid), 64'(0));
        check("skew_err", 64'(err_orphan), 64'(0));
        check("skew_pairs", 64'(n_pairs - base), 64'(3));

        // backpressure
        xbar_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) push_both(PW'(64'h3000 + i), AW'(32'h4000 + i));
        check("bp_prdy", 64'(phv_ready_out), 64'(0));
        check("bp_ardy", 64'(action_ready_out), 64'(0));
        for (int j = 0; j < 5; j++) begin
            check("bp_state", 64'(dut.state_q), 64'(2));
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_phv", 64'(phv_out), 64'h3000);
            check("bp_act", 64'(action_out), 64'(32'h4000));
            step();
        end
        base = n_pairs;
        xbar_ready_in = 1'b1;
        drain();
        check("bp_pairs", 64'(n_pairs - base), 64'(5));
        check("bp_cnt", 64'(pair_cnt), 64'(9));

        // counter wrap
        force dut.pair_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.pair_cnt_q;
        check("wrap_pre", 64'(pair_cnt), 64'(32'hFFFF_FFFF));
        push_both(64'hC0FFEE, 32'hBEEF);
        step();
        check("wrap_cnt", 64'(pair_cnt), 64'(0));
        drain();

        // orphan timeout
        push_phv(64'h5555);
        step(254);
        check("orph_early", 64'(err_orphan), 64'(0));
        check("orph_t254", 64'(dut.orphan_timer_q), 64'(254));
        step();
        check("orph_set", 64'(err_orphan), 64'(1));
        step(45);
        check("orph_sticky", 64'(err_orphan), 64'(1));
        check("orph_sat", 64'(dut.orphan_timer_q), 64'(255));
        base = n_pairs;
        push_act(32'h6666);
        drain();
        check("orph_pair", 64'(n_pairs - base), 64'(1));
        check("orph_keep", 64'(err_orphan), 64'(1));

        // reset mid-stall
        xbar_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) push_both(PW'(64'h7000 + i), AW'(32'h8000 + i));
        check("rs_valid_pre", 64'(out_valid), 64'(1));
        rst = 1'b1;
        #1;
        phv_q.delete();
        act_q.delete();
        check("rs_valid", 64'(out_valid), 64'(0));
        check("rs_phv", 64'(phv_out), 64'(0));
        check("rs_act", 64'(action_out), 64'(0));
        check("rs_cnt", 64'(pair_cnt), 64'(0));
        check("rs_err", 64'(err_orphan), 64'(0));
        check("rs_prdy", 64'(phv_ready_out), 64'(1));
        check("rs_ardy", 64'(action_ready_out), 64'(1));
        step(2);
        rst = 1'b0;
        xbar_ready_in = 1'b1;
        step();
        base = n_pairs;
        push_both(64'h9999, 32'hAAAA);
        drain();
        check("rs_pairs", 64'(n_pairs - base), 64'(1));
        check("rs_cnt_after", 64'(pair_cnt), 64'(1));
        check("rs_err_after", 64'(err_orphan), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
